fetch_decode_queue: RTL

- Small instruction queue between the Fetch stage and the Decode stage.
- Captures each fetched tuple {Instr, PC, PC+8} with a valid/ready handshake, so a stalled Decode does not lose fetched words.
- On a taken branch (PCSrc) the control unit raises flush, which discards all wrong-path entries.
- FIFO ordering, first-word-fall-through at the output.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fdq_storage.sv | 30 +++
 rtl/fetch_decode_queue.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: types and helpers shared by the fetch/decode instruction queue.
//   fdq_entry_t        one queued fetch tuple {instr, pc, pc8}
//   FDQ_DEPTH_DEFAULT  default queue depth
//   FDQ_WIDTH          width of each tuple field
//   fdq_cnt_w()        width of an occupancy counter able to hold 0..depth
package fetch_pkg;

   localparam int FDQ_DEPTH_DEFAULT = 4;
   localparam int FDQ_WIDTH         = 32;

   typedef struct packed {
      logic [FDQ_WIDTH-1:0] instr;
      logic [FDQ_WIDTH-1:0] pc;
      logic [FDQ_WIDTH-1:0] pc8;
   } fdq_entry_t;

   function automatic int fdq_cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fdq_storage.sv
// fdq_storage: DEPTH x fdq_entry_t register array.
//   CLK            clock
//   we/waddr/wdata synchronous write port
//   raddr/rdata    combinational read port
// Contents are not reset; occupancy tracking in the parent decides what is valid.
module fdq_storage
   import fetch_pkg::*;
#(
   parameter  int DEPTH = FDQ_DEPTH_DEFAULT,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  fdq_entry_t    wdata,
   input  logic [AW-1:0] raddr,
   output fdq_entry_t    rdata
);

   fdq_entry_t mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: FIFO between Fetch and Decode holding {instr, pc, pc8}
// tuples, first-word-fall-through at the head.
//   CLK, RST                  clock, synchronous active-high reset
//   flush                     discard all entries (branch redirect)
//   in_valid/in_ready, in_*   fetch side handshake and tuple
//   out_valid/out_ready, out_* decode side handshake and head tuple
//   count                     current occupancy
// Build option: FDQ_BYPASS_EN lets a word presented to an empty queue appear
// on out_* in the same cycle (and skip storage if Decode takes it).
module fetch_decode_queue
   import fetch_pkg::*;
#(
   parameter  int DEPTH = FDQ_DEPTH_DEFAULT,
   parameter  int WIDTH = FDQ_WIDTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = fdq_cnt_w(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_instr,
   input  logic [WIDTH-1:0] in_pc,
   input  logic [WIDTH-1:0] in_pc8,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_instr,
   output logic [WIDTH-1:0] out_pc,
   output logic [WIDTH-1:0] out_pc8,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count
);

   // entry fields are sized by the package, so WIDTH must match it
   if (WIDTH != FDQ_WIDTH || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
      $error("fetch_decode_queue: unsupported DEPTH/WIDTH");
   end

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;

   logic       empty;
   logic       full;
   logic       bypass;
   logic       push;
   logic       pop;
   logic       pass_thru;
   logic       do_write;
   logic       do_read;
   fdq_entry_t wr_entry;
   fdq_entry_t rd_entry;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);

   // in_ready looks at registered occupancy only; a full queue refuses
   // the word even if the head is leaving this cycle
   assign in_ready = ~full;

`ifdef FDQ_BYPASS_EN
   assign bypass = empty & in_valid & ~flush & ~RST;
`else
   assign bypass = 1'b0;
`endif

   assign out_valid = ~empty | bypass;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // a bypassed word consumed immediately never touches storage or pointers
   assign pass_thru = bypass & out_ready;
   assign do_write  = push & ~pass_thru;
   assign do_read   = pop & ~pass_thru;

   assign wr_entry.instr = in_instr;
   assign wr_entry.pc    = in_pc;
   assign wr_entry.pc8   = in_pc8;

   fdq_storage #(
      .DEPTH (DEPTH)
   ) u_storage (
      .CLK   (CLK),
      .we    (do_write & ~RST & ~flush),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );

   always_ff @(posedge CLK) begin
      if (RST || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_read) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_write, do_read})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign count = count_q;

   // head is zeroed when nothing is valid so Decode never sees stale words
   always_comb begin
      out_instr = '0;
      out_pc    = '0;
      out_pc8   = '0;
      if (bypass) begin
         out_instr = in_instr;
         out_pc    = in_pc;
         out_pc8   = in_pc8;
      end else if (!empty) begin
         out_instr = rd_entry.instr;
         out_pc    = rd_entry.pc;
         out_pc8   = rd_entry.pc8;
      end
   end

endmodule
